// File: rtl/ps2_kbd_receiver.sv
// ps2_kbd_receiver: PS/2 keyboard host receiver feeding an 8-deep scan-code FIFO
// Ports:
//   clk        system clock, all state on rising edge
//   clrn       asynchronous active-low reset
//   ps2_clk    keyboard clock (asynchronous), data sampled on its falling edge
//   ps2_data   keyboard data
//   nextdata_n active-low pop strobe, honoured only while ready=1
//   data       FIFO head byte
//   ready      FIFO non-empty
//   overflow   sticky, a valid byte was dropped because the FIFO was full
module ps2_kbd_receiver #(
    parameter int FIFO_AW = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow
);
    localparam int DEPTH = 2 ** FIFO_AW;
    logic [2:0]         clk_sync;
    logic [9:0]         buffer;
    logic [3:0]         count;
    logic [7:0]         fifo [DEPTH];
    logic [FIFO_AW-1:0] w_ptr, r_ptr;
    logic [FIFO_AW:0]   occ;
    logic               sample, frame_ok, full, pop, push;
    assign sample   = clk_sync[2] & ~clk_sync[1];
    // start bit low, stop bit (current sample) high, odd parity over d0..d7 plus parity
    assign frame_ok = sample && count == 4'd10 && !buffer[0] && ps2_data && ^buffer[9:1];
    // occupancy never exceeds DEPTH, so its MSB alone flags full
    assign full     = occ[FIFO_AW];
    assign ready    = occ != '0;
    assign pop      = ready && !nextdata_n;
    // a pop in the same cycle frees a slot, so a full FIFO still takes the byte
    assign push     = frame_ok && (!full || pop);
    assign data     = fifo[r_ptr];
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync <= 3'b111;
            buffer   <= '0;
            count    <= '0;
            w_ptr    <= '0;
            r_ptr    <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            if (sample) begin
                if (count == 4'd10) begin
                    count <= '0;
                end else begin
                    buffer[count] <= ps2_data;
                    count         <= count + 4'd1;
                end
            end
            if (frame_ok && !push) overflow <= 1'b1;
            if (push) w_ptr <= w_ptr + FIFO_AW'(1);
            if (pop) r_ptr <= r_ptr + FIFO_AW'(1);
            occ <= occ + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
        end
    end
    always_ff @(posedge clk) begin
        if (push) fifo[w_ptr] <= buffer[8:1];
    end
endmodule

// File: tb/tb_ps2_kbd_receiver.sv
// tb_ps2_kbd_receiver: scoreboard bench for the PS/2 receiver
module tb_ps2_kbd_receiver;
    localparam int HALF = 20;
    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       drain_en = 1'b0;
    logic       force_pop = 1'b0;
    logic [7:0] exp_q [$];
    int         tests = 0;
    int         fails = 0;

    ps2_kbd_receiver dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nextdata_n), .data(data), .ready(ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // consumer: settles nextdata_n shortly after each rising edge
    always begin
        @(posedge clk);
        #2 nextdata_n = ~((drain_en && ready) || force_pop);
    end

    // monitor: every pop the DUT is about to perform is checked against the queue head
    always @(negedge clk) begin
        if (clrn && ready && !nextdata_n) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got data=%02h, required no byte", data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (data !== e) begin
                    fails++;
                    $display("FAIL pop_data: got %02h, required %02h", data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %02h, required %02h", name, got, want);
        end
    endtask

    // odd parity bit p makes XOR(d0..d7,p)=1
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                              input int nbits, input logic pop_on_stop);
        logic [10:0] f;
        f = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk);
            #1 ps2_data = f[i];
            repeat (HALF) @(posedge clk);
            #1 ps2_clk = 1'b0;
            if (pop_on_stop && i == 10) begin
                // third rising edge after the pin edge samples the stop bit; pop on that edge
                @(posedge clk);
                @(posedge clk);
                #1 force_pop = 1'b1;
                @(posedge clk);
                #1 force_pop = 1'b0;
                repeat (HALF - 3) @(posedge clk);
            end else begin
                repeat (HALF) @(posedge clk);
            end
            #1 ps2_clk = 1'b1;
        end
        repeat (6) @(posedge clk);
    endtask

    task automatic send_ok(input logic [7:0] b, input logic expect_store);
        if (expect_store) exp_q.push_back(b);
        send_frame(b, 1'b0, 1'b1, 11, 1'b0);
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: got %0d bytes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 clrn = 1'b0;
        repeat (3) @(posedge clk);
        #3 clrn = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #3;
        check("reset_ready", {7'd0, ready}, 8'h00);
        check("reset_overflow", {7'd0, overflow}, 8'h00);
        #1 clrn = 1'b1;

        drain_en = 1'b1;
        send_ok(8'h1C, 1'b1);
        send_ok(8'hF0, 1'b1);
        send_ok(8'h1C, 1'b1);
        send_ok(8'h1B, 1'b1);
        send_ok(8'hF0, 1'b1);
        send_ok(8'h1B, 1'b1);
        wait_empty("seq");
        check("seq_ready", {7'd0, ready}, 8'h00);
        check("seq_overflow", {7'd0, overflow}, 8'h00);

        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
        send_ok(8'h1B, 1'b1);
        wait_empty("parity");
        check("parity_overflow", {7'd0, overflow}, 8'h00);

        send_frame(8'h55, 1'b0, 1'b0, 11, 1'b0);
        repeat (10) @(posedge clk);
        #3 check("badstop_ready", {7'd0, ready}, 8'h00);
        send_ok(8'hAA, 1'b1);
        wait_empty("resync");
        check("resync_overflow", {7'd0, overflow}, 8'h00);

        drain_en = 1'b0;
        for (int i = 1; i <= 9; i++) send_ok(8'(i), i <= 8);
        #3;
        check("full_ready", {7'd0, ready}, 8'h01);
        check("full_head", data, 8'h01);
        check("full_overflow", {7'd0, overflow}, 8'h01);
        drain_en = 1'b1;
        wait_empty("drain");
        check("drain_ready", {7'd0, ready}, 8'h00);
        check("drain_overflow", {7'd0, overflow}, 8'h01);

        drain_en = 1'b0;
        send_frame(8'h1B, 1'b0, 1'b1, 5, 1'b0);
        #3 clrn = 1'b0;
        #1;
        check("midreset_ready", {7'd0, ready}, 8'h00);
        check("midreset_overflow", {7'd0, overflow}, 8'h00);
        repeat (3) @(posedge clk);
        #3 clrn = 1'b1;
        ps2_data = 1'b1;
        drain_en = 1'b1;
        send_ok(8'h1B, 1'b1);
        wait_empty("midreset");
        check("midreset_after_ready", {7'd0, ready}, 8'h00);

        do_reset();
        drain_en = 1'b0;
        for (int i = 1; i <= 8; i++) send_ok(8'(i), 1'b1);
        exp_q.push_back(8'h09);
        send_frame(8'h09, 1'b0, 1'b1, 11, 1'b1);
        #3;
        check("simul_overflow", {7'd0, overflow}, 8'h00);
        check("simul_head", data, 8'h02);
        drain_en = 1'b1;
        wait_empty("simul");
        check("simul_ready", {7'd0, ready}, 8'h00);
        check("simul_overflow_end", {7'd0, overflow}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ps2_kbd_receiver.md
Name: ps2_kbd_receiver

Overview:
PS/2 keyboard host-side receiver. Samples the device-driven ps2_clk/ps2_data lines in the system clock domain and deserialises 11-bit frames. Valid scan-code bytes go into a small FIFO, which the consumer drains through a ready/nextdata_n handshake. Sits between the board PS/2 pins (or a keyboard behavioural model in simulation) and the scan-code decoder.

Parameters:
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW = 8 entries (usable capacity 8, see overflow rule).

Ports:
clk  input  1  system clock (100 MHz nominal); all state on rising edge
clrn  input  1  asynchronous active-low reset
ps2_clk  input  1  PS/2 clock from keyboard (~10-17 kHz, asynchronous to clk)
ps2_data  input  1  PS/2 data from keyboard, valid on ps2_clk falling edge
nextdata_n  input  1  active-low read strobe; pops head byte when low and ready=1
data  output  8  FIFO head byte (combinational from head entry)
ready  output  1  1 = FIFO non-empty, data valid
overflow  output  1  sticky; 1 = at least one complete valid byte was dropped because FIFO was full

Behaviour:
- Reset (clrn=0, async): shift count=0, shift register=0, FIFO pointers=0, entry count=0, ready=0, overflow=0, sync flops=1 (idle line). data is don't-care while ready=0.
- Synchronisation: ps2_clk passes through a 3-flop shift chain. Falling edge = previous sample 1, current sample 0. Exactly one sampling event per PS/2 falling edge. ps2_data is sampled on that same cycle.
- Frame: 11 bits, LSB first: start(0), d0..d7, odd parity, stop(1). Bit counter 0..10.
- Bits 0-9 are stored in a 10-bit buffer at index = count; count increments.
- On the 11th event (count=10):
  - Frame is valid iff start=0, stop(current ps2_data)=1, and XOR(d0..d7,parity)=1 (odd parity).
  - Valid and FIFO not full: write d7..d0 at write pointer; write pointer +1 (mod depth).
  - Valid and FIFO full: drop the byte and set overflow=1.
  - Invalid: drop the byte silently; overflow unchanged.
  - count returns to 0 in every case.
- FIFO: 8 entries, separate 3-bit read/write pointers plus a 4-bit occupancy counter (0..8). ready = (occupancy != 0).
- Read: on a clk edge with ready=1 and nextdata_n=0, read pointer +1 and occupancy -1. nextdata_n=0 while ready=0 is ignored. data shows the new head in the following cycle. A consumer holding nextdata_n low consumes one byte per clk.
- Simultaneous write and read in the same cycle: both pointers advance and occupancy is unchanged. If the FIFO is full, the read frees a slot first and the write is accepted, so overflow is not set.
- overflow stays set until reset; reads do not clear it.
- There is no frame timeout. A glitched partial frame stays until the next 11 edges complete or until reset.
- Reset mid-frame discards the partial frame and all buffered bytes.
- Latency: byte visible (ready=1) 1 clk after the clk edge that samples the stop bit; sync adds 3 clk from the pin edge.

Test Plan:
- After reset: ready=0, overflow=0. Send frames 0x1C, 0xF0, 0x1C, 0x1B, 0xF0, 0x1B with nextdata_n=~ready -> ready pulses once per frame and data reads exactly 1C,F0,1C,1B,F0,1B in order; overflow=0.
- Send 0x1C with a wrong parity bit, then a correct 0x1B -> only 0x1B is delivered; overflow=0.
- Send 0x55 with stop bit 0 -> no byte, ready stays 0; a following valid 0xAA is delivered correctly, proving the frame counter resynced.
- Hold nextdata_n=1 and send 9 valid bytes 0x01..0x09 -> occupancy 8, overflow=1 after the 9th frame. Then drain -> reads 01..08, ready=0 after the 8th pop, overflow still 1.
- With the FIFO full, assert a pop on the same clk as the 9th stop-bit sample -> byte 0x09 accepted and overflow=0.
- Pulse clrn low after 5 bits of a frame, then send 0x1B -> exactly 0x1B received; ready=0 and overflow=0 immediately on reset assertion.
